// File: rtl/yuv2rgb_out.sv
// rtl/yuv2rgb_out.sv - HuC6261 YUV/sync to clamped RGB output pipeline
module yuv2rgb_out #(
  parameter bit BLANK_ZERO = 1'b1
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       PCE,
  input  logic [7:0] Y,
  input  logic [7:0] U,
  input  logic [7:0] V,
  input  logic       HSn,
  input  logic       VSn,
  input  logic       HBL,
  input  logic       VBL,
  output logic [7:0] R,
  output logic [7:0] G,
  output logic [7:0] B,
  output logic       HS_OUTn,
  output logic       VS_OUTn,
  output logic       HBL_OUT,
  output logic       VBL_OUT,
  output logic       DE,
  output logic       PCE_OUT
);

  logic              run;
  logic              en;

  logic        [7:0] s1_y;
  logic signed [8:0] s1_u;
  logic signed [8:0] s1_v;
  logic              s1_hsn, s1_vsn, s1_hbl, s1_vbl;

  logic        [7:0]  s2_y;
  logic signed [17:0] s2_pr, s2_pg, s2_pb;
  logic               s2_hsn, s2_vsn, s2_hbl, s2_vbl;

  logic signed [17:0] u_ext, v_ext;
  logic signed [17:0] pr_c, pg_c, pb_c;
  logic signed [10:0] t_r, t_g, t_b;
  logic        [7:0]  r_c, g_c, b_c;

  function automatic logic [7:0] clamp8(input logic signed [10:0] t);
    if (t < 11'sd0)
      return 8'd0;
    else if (t > 11'sd255)
      return 8'd255;
    else
      return t[7:0];
  endfunction

  // run stays low through the first edge after reset so a PCE coinciding with release is dropped
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) run <= 1'b0;
    else     run <= 1'b1;
  end

  assign en = PCE & run;

  // S1: capture luma, re-centred chroma and the raw flags
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      s1_y   <= 8'd0;
      s1_u   <= 9'sd0;
      s1_v   <= 9'sd0;
      s1_hsn <= 1'b1;
      s1_vsn <= 1'b1;
      s1_hbl <= 1'b1;
      s1_vbl <= 1'b1;
    end else if (en) begin
      s1_y   <= Y;
      s1_u   <= $signed({1'b0, U} - 9'd128);
      s1_v   <= $signed({1'b0, V} - 9'd128);
      s1_hsn <= HSn;
      s1_vsn <= VSn;
      s1_hbl <= HBL;
      s1_vbl <= VBL;
    end
  end

  // Chroma products in 8.8 fixed point; all fit comfortably in 18 signed bits
  always_comb begin
    u_ext = {{9{s1_u[8]}}, s1_u};
    v_ext = {{9{s1_v[8]}}, s1_v};
    pr_c  = 18'sd359 * v_ext;
    pg_c  = -(18'sd88 * u_ext) - (18'sd183 * v_ext);
    pb_c  = 18'sd454 * u_ext;
  end

  // S2: register the products alongside luma and flags
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      s2_y   <= 8'd0;
      s2_pr  <= 18'sd0;
      s2_pg  <= 18'sd0;
      s2_pb  <= 18'sd0;
      s2_hsn <= 1'b1;
      s2_vsn <= 1'b1;
      s2_hbl <= 1'b1;
      s2_vbl <= 1'b1;
    end else if (en) begin
      s2_y   <= s1_y;
      s2_pr  <= pr_c;
      s2_pg  <= pg_c;
      s2_pb  <= pb_c;
      s2_hsn <= s1_hsn;
      s2_vsn <= s1_vsn;
      s2_hbl <= s1_hbl;
      s2_vbl <= s1_vbl;
    end
  end

  // Add floored chroma terms to luma, clamp, and black out blanked pixels when enabled
  always_comb begin
    t_r = 11'($signed({10'd0, s2_y}) + (s2_pr >>> 8));
    t_g = 11'($signed({10'd0, s2_y}) + (s2_pg >>> 8));
    t_b = 11'($signed({10'd0, s2_y}) + (s2_pb >>> 8));
    r_c = clamp8(t_r);
    g_c = clamp8(t_g);
    b_c = clamp8(t_b);
    if (BLANK_ZERO && (s2_hbl || s2_vbl)) begin
      r_c = 8'd0;
      g_c = 8'd0;
      b_c = 8'd0;
    end
  end

  // S3: output registers, holding between pixel enables
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      R       <= 8'd0;
      G       <= 8'd0;
      B       <= 8'd0;
      HS_OUTn <= 1'b1;
      VS_OUTn <= 1'b1;
      HBL_OUT <= 1'b1;
      VBL_OUT <= 1'b1;
      DE      <= 1'b0;
    end else if (en) begin
      R       <= r_c;
      G       <= g_c;
      B       <= b_c;
      HS_OUTn <= s2_hsn;
      VS_OUTn <= s2_vsn;
      HBL_OUT <= s2_hbl;
      VBL_OUT <= s2_vbl;
      DE      <= ~(s2_hbl | s2_vbl);
    end
  end

  // Pixel strobe delayed one clock to mark the first cycle of each new output
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) PCE_OUT <= 1'b0;
    else     PCE_OUT <= en;
  end

endmodule

// File: tb/tb_yuv2rgb_out.sv
// tb/tb_yuv2rgb_out.sv - randomized self-checking bench for yuv2rgb_out
module tb_yuv2rgb_out;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] u;
    logic [7:0] v;
    logic       hsn;
    logic       vsn;
    logic       hbl;
    logic       vbl;
  } pix_t;

  localparam logic [28:0] RST_VEC = {24'd0, 4'b1111, 1'b0};

  logic       CLK = 1'b0;
  logic       RES = 1'b1;
  logic       PCE = 1'b0;
  logic [7:0] Y = 8'd0, U = 8'd128, V = 8'd128;
  logic       HSn = 1'b1, VSn = 1'b1, HBL = 1'b0, VBL = 1'b0;

  logic [7:0] r1, g1, b1, r0, g0, b0;
  logic       hs1, vs1, hbl1, vbl1, de1, po1;
  logic       hs0, vs0, hbl0, vbl0, de0, po0;

  int   checks = 0;
  int   errors = 0;
  pix_t hist[$];
  bit   m_run;
  bit   exp_po;
  pix_t rst_pix;

  yuv2rgb_out #(.BLANK_ZERO(1'b1)) dut1 (
    .CLK(CLK), .RES(RES), .PCE(PCE), .Y(Y), .U(U), .V(V),
    .HSn(HSn), .VSn(VSn), .HBL(HBL), .VBL(VBL),
    .R(r1), .G(g1), .B(b1), .HS_OUTn(hs1), .VS_OUTn(vs1),
    .HBL_OUT(hbl1), .VBL_OUT(vbl1), .DE(de1), .PCE_OUT(po1)
  );

  yuv2rgb_out #(.BLANK_ZERO(1'b0)) dut0 (
    .CLK(CLK), .RES(RES), .PCE(PCE), .Y(Y), .U(U), .V(V),
    .HSn(HSn), .VSn(VSn), .HBL(HBL), .VBL(VBL),
    .R(r0), .G(g0), .B(b0), .HS_OUTn(hs0), .VS_OUTn(vs0),
    .HBL_OUT(hbl0), .VBL_OUT(vbl0), .DE(de0), .PCE_OUT(po0)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int floor256(input int a);
    if (a >= 0) return a / 256;
    return -((-a + 255) / 256);
  endfunction

  function automatic logic [7:0] sat8(input int t);
    if (t < 0) return 8'd0;
    if (t > 255) return 8'd255;
    return t[7:0];
  endfunction

  // Expected output word {R,G,B,HS,VS,HBL,VBL,DE} for one pixel
  function automatic logic [28:0] expect_out(input pix_t p, input bit bz);
    int u, v, yy;
    logic [7:0] r, g, b;
    logic blank;
    u  = int'(p.u) - 128;
    v  = int'(p.v) - 128;
    yy = int'(p.y);
    r  = sat8(yy + floor256(359 * v));
    g  = sat8(yy + floor256(-88 * u - 183 * v));
    b  = sat8(yy + floor256(454 * u));
    blank = p.hbl | p.vbl;
    if (bz && blank) begin
      r = 8'd0; g = 8'd0; b = 8'd0;
    end
    return {r, g, b, p.hsn, p.vsn, p.hbl, p.vbl, ~blank};
  endfunction

  function automatic logic [28:0] vec1();
    return {r1, g1, b1, hs1, vs1, hbl1, vbl1, de1};
  endfunction

  function automatic logic [28:0] vec0();
    return {r0, g0, b0, hs0, vs0, hbl0, vbl0, de0};
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 3; i++) hist.push_back(rst_pix);
    m_run  = 1'b0;
    exp_po = 1'b0;
  endtask

  // One clock: apply PCE, advance the model on the edge, compare on the falling edge
  task automatic step(input bit pce_i);
    bit eff;
    pix_t p;
    PCE = pce_i;
    @(posedge CLK);
    eff    = PCE && m_run && !RES;
    m_run  = !RES;
    exp_po = eff;
    if (eff) begin
      p = '{y: Y, u: U, v: V, hsn: HSn, vsn: VSn, hbl: HBL, vbl: VBL};
      hist.push_back(p);
      void'(hist.pop_front());
    end
    @(negedge CLK);
    check_eq("out_bz1", {3'b0, vec1()}, {3'b0, expect_out(hist[0], 1'b1)});
    check_eq("out_bz0", {3'b0, vec0()}, {3'b0, expect_out(hist[0], 1'b0)});
    check_eq("pce_out", {30'd0, po1, po0}, {30'd0, exp_po, exp_po});
  endtask

  task automatic pulse(input int gap);
    for (int i = 1; i < gap; i++) step(1'b0);
    step(1'b1);
  endtask

  task automatic set_pix(input logic [7:0] y, input logic [7:0] u, input logic [7:0] v,
                         input logic hs, input logic hb);
    Y = y; U = u; V = v; HSn = hs; VSn = 1'b1; HBL = hb; VBL = 1'b0;
  endtask

  initial begin
    rst_pix = '{y: 8'd0, u: 8'd128, v: 8'd128, hsn: 1'b1, vsn: 1'b1, hbl: 1'b1, vbl: 1'b1};
    model_reset();
    @(negedge CLK);
    check_eq("reset_vec", {3'b0, vec1()}, {3'b0, RST_VEC});
    step(1'b0);
    // Release reset with PCE high in the same cycle: that pulse must be ignored
    RES = 1'b0;
    set_pix(8'd128, 8'd128, 8'd128, 1'b1, 1'b0);
    step(1'b1);
    check_eq("rel_pce_ign", {3'b0, vec1()}, {3'b0, RST_VEC});

    for (int i = 0; i < 3; i++) pulse(8);
    check_eq("grey", {r1, g1, b1, de1}, {8'd128, 8'd128, 8'd128, 1'b1});

    set_pix(8'd255, 8'd128, 8'd255, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) pulse(8);
    check_eq("sat_hi", {8'd0, r1, g1, b1}, {8'd0, 8'd255, 8'd164, 8'd255});

    set_pix(8'd0, 8'd0, 8'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) pulse(8);
    check_eq("sat_lo", {8'd0, r1, g1, b1}, {8'd0, 8'd0, 8'd135, 8'd0});

    set_pix(8'd200, 8'd128, 8'd128, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) pulse(8);
    check_eq("blank_bz1", {r1, g1, b1, hbl1, de1}, {8'd0, 8'd0, 8'd0, 1'b1, 1'b0});
    check_eq("blank_bz0", {r0, g0, b0, hbl0, de0}, {8'd200, 8'd200, 8'd200, 1'b1, 1'b0});

    // Irregular spacing with a ramp and a two-pixel HSn pulse
    for (int i = 0; i < 9; i++) begin
      set_pix(8'(10 * (i + 1)), 8'd128, 8'd128, (i == 3 || i == 4) ? 1'b0 : 1'b1, 1'b0);
      pulse((i % 3 == 0) ? 6 : (i % 3 == 1) ? 8 : 1);
    end
    check_eq("ramp_last", {24'd0, r1}, {24'd0, 8'd70});

    // Mid-line asynchronous reset
    @(posedge CLK); #2;
    RES = 1'b1;
    #1;
    check_eq("async_rst", {3'b0, vec1()}, {3'b0, RST_VEC});
    check_eq("async_po", {31'd0, po1}, 32'd0);
    model_reset();
    @(negedge CLK);
    step(1'b1);
    RES = 1'b0;
    set_pix(8'd90, 8'd128, 8'd128, 1'b1, 1'b0);
    step(1'b1);
    pulse(2);
    check_eq("post_rst_blk", {31'd0, de1}, 32'd0);
    pulse(3);
    check_eq("post_rst_blk2", {31'd0, de1}, 32'd0);
    pulse(1);
    check_eq("post_rst_live", {23'd0, de1, r1}, {23'd0, 1'b1, 8'd90});

    // Random pixels, flags and spacing, with occasional resets
    for (int n = 0; n < 600; n++) begin
      Y   = 8'($urandom);
      U   = 8'($urandom);
      V   = 8'($urandom);
      HSn = ($urandom_range(0, 7) != 0);
      VSn = ($urandom_range(0, 15) != 0);
      HBL = ($urandom_range(0, 3) == 0);
      VBL = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 99) == 0) begin
        RES = 1'b1;
        #1;
        check_eq("rand_rst", {3'b0, vec0()}, {3'b0, RST_VEC});
        model_reset();
        step(1'b1);
        RES = 1'b0;
      end
      pulse($urandom_range(1, 6));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/yuv2rgb_out.md
# yuv2rgb_out

Video output converter between the HuC6261 mixer's YUV/sync outputs and the RGB video output path. It samples Y/U/V and the sync/blank flags on each pixel clock enable from the 6261, and converts with fixed-point BT.601-style coefficients. It clamps to 8 bits, forces black during blanking, and delays all sync/blank flags to stay aligned with the pixel data.

## Interface
Parameters:
- BLANK_ZERO, 1, when 1, R/G/B are forced to 0 while either blank flag is set at the output stage; when 0, converted values pass through during blanking.

Ports:
- CLK  in  1  system clock; the only clock.
- RES  in  1  reset; asynchronous and active-high.
- PCE  in  1  pixel clock enable from HuC6261; every pipeline stage advances only on cycles with PCE=1.
- Y  in  8  luma, unsigned.
- U  in  8  chroma U, offset-binary (128 = zero).
- V  in  8  chroma V, offset-binary (128 = zero).
- HSn  in  1  horizontal sync, active-low.
- VSn  in  1  vertical sync, active-low.
- HBL  in  1  horizontal blank, active-high.
- VBL  in  1  vertical blank, active-high.
- R, G, B  out  8 each  converted colour.
- HS_OUTn, VS_OUTn  out  1 each  delayed syncs, active-low.
- HBL_OUT, VBL_OUT  out  1 each  delayed blanks.
- DE  out  1  display enable, = ~(HBL_OUT | VBL_OUT), registered.
- PCE_OUT  out  1  PCE delayed one CLK; consumers sample outputs when it is 1.

## Operation
- Three-stage pipeline, stage enable = PCE:
  - S1 captures Y, u = U-128, v = V-128 (9-bit signed), and the flags HSn, VSn, HBL, VBL.
  - S2 computes the products:
    - pr = 359*v
    - pg = -(88*u) - (183*v)
    - pb = 454*u
    - Products are 18-bit signed; Y and the flags pass along.
  - S3 computes tR = Y + (pr >>> 8), tG = Y + (pg >>> 8), tB = Y + (pb >>> 8).
    - >>> is an arithmetic shift (floor).
    - Sums are 11-bit signed.
    - Each is clamped: <0 → 0, >255 → 255.
    - If BLANK_ZERO and (HBL|VBL of this pixel), the result is 0.
    - Results and flags are registered to the outputs.
- Flags travel with their pixel through all three stages. No flag bypasses the pipeline.
- No state outside the pipeline. Output registers hold their value between PCE pulses.

## Timing
- Latency: an input sampled on PCE pulse n appears on R/G/B and the flag outputs in the CLK after PCE pulse n+2. It is valid on the PCE_OUT pulse that follows.
- PCE_OUT is PCE registered once, so it coincides with the first CLK in which the new output is stable.
- PCE spacing is arbitrary (≥1 CLK), including back-to-back and irregular patterns caused by dc7 switching. The pipeline must not assume a fixed divider.
- PCE=0 on every cycle: all registers hold indefinitely.
- Reset values, applied immediately and asynchronously:
  - R=G=B=0
  - HS_OUTn=VS_OUTn=1
  - HBL_OUT=VBL_OUT=1
  - DE=0, PCE_OUT=0
  - All internal stage registers reset to the same values: data 0, syncs 1, blanks 1.
- Reset asserted mid-line: outputs take their reset values in the same cycle. After release, the first three PCE pulses shift the reset contents out (blanked, syncs inactive) before real pixels emerge.
- PCE in the same cycle as reset release: that PCE is ignored. Sampling starts on the next PCE.
- A flag edge and a pixel change in the same PCE stay in the same pipeline slot at the output.

## Test plan
- Y=128, U=128, V=128, HBL=VBL=0, PCE every 8 CLK → after 3 PCE: R=G=B=128, DE=1.
- Y=255, U=128, V=255 → R=255 (clamped), G=164, B=255.
- Y=0, U=0, V=0 → R=0 (clamped from -180), G=135, B=0 (clamped from -227).
- HBL=1 with Y=200, U=V=128:
  - BLANK_ZERO=1 → R=G=B=0, HBL_OUT=1, DE=0, on the same slot as the pixel.
  - BLANK_ZERO=0 → R=G=B=200.
- Irregular PCE (spacing 6, then 8, then 1 CLK), incrementing Y 10, 20, 30, ... with U=V=128 → outputs emerge 10, 20, 30 in order, each exactly two PCE pulses after capture. HSn pulse width is preserved in PCE units.
- RES pulsed for 1 CLK mid-frame → in that cycle R/G/B=0, HS_OUTn=VS_OUTn=1, DE=0. The next three output slots after release are blanked, then live data resumes.
